// File: rtl/rv32im_lsu_hs_pkg.sv
// Shared definitions for the RV32IM load/store unit.
// Holds the opcode encoding, the response error codes, the FSM state
// encoding and small decode helpers used by the LSU and the testbench.
package rv32im_lsu_hs_pkg;

    localparam int LSU_OPCODE_WIDTH = 4;

    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LB  = 4'd0;
    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LBU = 4'd1;
    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LH  = 4'd2;
    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LHU = 4'd3;
    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LW  = 4'd4;
    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_SB  = 4'd5;
    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_SH  = 4'd6;
    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_SW  = 4'd7;
    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LD  = 4'd8;
    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_SD  = 4'd9;

    localparam logic [1:0] LSU_ERR_OK       = 2'd0;
    localparam logic [1:0] LSU_ERR_MISALIGN = 2'd1;
    localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // log2 of the access size in bytes: 0=B, 1=H, 2=W, 3=D
    function automatic logic [1:0] op_size(input logic [LSU_OPCODE_WIDTH-1:0] op);
        case (op)
            LSU_OPCODE_LH, LSU_OPCODE_LHU, LSU_OPCODE_SH: op_size = 2'd1;
            LSU_OPCODE_LW, LSU_OPCODE_SW:                 op_size = 2'd2;
            LSU_OPCODE_LD, LSU_OPCODE_SD:                 op_size = 2'd3;
            default:                                      op_size = 2'd0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [LSU_OPCODE_WIDTH-1:0] op);
        op_is_store = (op == LSU_OPCODE_SB) || (op == LSU_OPCODE_SH) ||
                      (op == LSU_OPCODE_SW) || (op == LSU_OPCODE_SD);
    endfunction

    function automatic logic op_is_signed(input logic [LSU_OPCODE_WIDTH-1:0] op);
        op_is_signed = (op == LSU_OPCODE_LB) || (op == LSU_OPCODE_LH) ||
                       (op == LSU_OPCODE_LW) || (op == LSU_OPCODE_LD);
    endfunction

    // Doubleword accesses only exist on a 64-bit bus.
    function automatic logic op_is_legal(input logic [LSU_OPCODE_WIDTH-1:0] op,
                                         input int data_w);
        case (op)
            LSU_OPCODE_LB, LSU_OPCODE_LBU, LSU_OPCODE_LH, LSU_OPCODE_LHU,
            LSU_OPCODE_LW, LSU_OPCODE_SB, LSU_OPCODE_SH, LSU_OPCODE_SW:
                op_is_legal = 1'b1;
            LSU_OPCODE_LD, LSU_OPCODE_SD:
                op_is_legal = (data_w == 64);
            default:
                op_is_legal = 1'b0;
        endcase
    endfunction

    // Byte-enable pattern of an access placed at lane offset off.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        lane_mask = m << off;
    endfunction

endpackage

// File: rtl/rv32im_lsu_hs_if.sv
// Bundle of the LSU handshakes: execute-unit request/response and the
// memory request/completion channel.
//   slave  : the LSU side (takes requests, drives memory requests)
//   master : the environment side (execute unit + memory)
interface rv32im_lsu_hs_if
    import rv32im_lsu_hs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                        req_valid_i;
    logic                        req_ready_o;
    logic [LSU_OPCODE_WIDTH-1:0] lsu_opcode_i;
    logic [ADDR_W-1:0]           addr_i;
    logic [DATA_W-1:0]           wdata_i;
    logic                        rsp_valid_o;
    logic [DATA_W-1:0]           rdata_o;
    logic [1:0]                  err_o;
    logic                        mem_req_o;
    logic                        mem_gnt_i;
    logic [ADDR_W-1:0]           mem_addr_o;
    logic                        mem_we_o;
    logic [DATA_W/8-1:0]         mem_be_o;
    logic [DATA_W-1:0]           mem_wdata_o;
    logic                        mem_rvalid_i;
    logic [DATA_W-1:0]           mem_rdata_i;

    modport slave (
        input  req_valid_i, lsu_opcode_i, addr_i, wdata_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rdata_o, err_o,
               mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, lsu_opcode_i, addr_i, wdata_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rdata_o, err_o,
               mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
    );
endinterface

// File: rtl/rv32im_lsu_align.sv
// Byte-lane alignment for the LSU.
//   load_i=0 : data_i shifted up by off_i bytes (store data to its lanes)
//   load_i=1 : data_i shifted down by off_i bytes, truncated to the access
//              size and sign- (sext_i=1) or zero-extended
// Ports: load_i, off_i (lane offset), size_i (log2 bytes), sext_i,
//        data_i, data_o. Purely combinational.
module rv32im_lsu_align #(
    parameter int DATA_W = 32
) (
    input  logic                          load_i,
    input  logic [$clog2(DATA_W/8)-1:0]   off_i,
    input  logic [1:0]                    size_i,
    input  logic                          sext_i,
    input  logic [DATA_W-1:0]             data_i,
    output logic [DATA_W-1:0]             data_o
);
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep;
    logic              msb;

    always_comb begin
        shifted = load_i ? (data_i >> {off_i, 3'b000}) : (data_i << {off_i, 3'b000});
        case (size_i)
            2'd0:    begin keep = DATA_W'({8{1'b1}});  msb = shifted[7];        end
            2'd1:    begin keep = DATA_W'({16{1'b1}}); msb = shifted[15];       end
            2'd2:    begin keep = DATA_W'({32{1'b1}}); msb = shifted[31];       end
            default: begin keep = '1;                  msb = shifted[DATA_W-1]; end
        endcase
        data_o = shifted;
        if (load_i)
            data_o = (shifted & keep) | (~keep & {DATA_W{sext_i & msb}});
    end
endmodule

// File: rtl/rv32im_lsu_hs.sv
// RV32IM load/store unit with a single outstanding memory transaction.
// Accepts one request in IDLE, rejects misaligned/unknown accesses with
// an immediate err=1 response, otherwise issues a memory request, waits
// for completion (bounded by a timeout) and returns one response cycle.
// Ports: clk_i, rst_ni (sync, active low), bus (rv32im_lsu_hs_if.slave).
module rv32im_lsu_hs
    import rv32im_lsu_hs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int TMO_W  = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    rv32im_lsu_hs_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    // Counter starts at 0 on WAIT entry, so reaching 2^TMO_W-2 means
    // 2^TMO_W-1 WAIT cycles have elapsed without completion.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    lsu_state_e                  state_q, state_d;
    logic [LSU_OPCODE_WIDTH-1:0] op_q;
    logic [ADDR_W-1:0]           addr_q;
    logic [DATA_W-1:0]           wdata_q, rdata_q, st_data, ld_data;
    logic [1:0]                  err_q, size_q, size_in;
    logic [TMO_W-1:0]            tmo_q;
    logic [OFF_W-1:0]            off_q;
    logic                        acc_bad, tmo_hit;

    assign size_in = op_size(bus.lsu_opcode_i);
    assign acc_bad = !op_is_legal(bus.lsu_opcode_i, DATA_W) ||
                     (|(bus.addr_i[OFF_W-1:0] & OFF_W'((1 << size_in) - 1)));
    assign size_q  = op_size(op_q);
    assign off_q   = addr_q[OFF_W-1:0];
    assign tmo_hit = (tmo_q == TMO_LAST);

    rv32im_lsu_align #(.DATA_W(DATA_W)) u_st_align (
        .load_i (1'b0),
        .off_i  (off_q),
        .size_i (size_q),
        .sext_i (1'b0),
        .data_i (wdata_q),
        .data_o (st_data)
    );

    rv32im_lsu_align #(.DATA_W(DATA_W)) u_ld_align (
        .load_i (1'b1),
        .off_i  (off_q),
        .size_i (size_q),
        .sext_i (op_is_signed(op_q)),
        .data_i (bus.mem_rdata_i),
        .data_o (ld_data)
    );

    // Address and store data come straight from the captured request, so
    // they stay stable for the whole REQ phase regardless of the inputs.
    assign bus.req_ready_o = (state_q == ST_IDLE);
    assign bus.rsp_valid_o = (state_q == ST_RESP);
    assign bus.rdata_o     = rdata_q;
    assign bus.err_o       = err_q;
    assign bus.mem_req_o   = (state_q == ST_REQ);
    assign bus.mem_we_o    = (state_q == ST_REQ) && op_is_store(op_q);
    assign bus.mem_be_o    = (state_q == ST_REQ) ? BE_W'(lane_mask(size_q, 3'(off_q))) : '0;
    assign bus.mem_addr_o  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign bus.mem_wdata_o = st_data;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.req_valid_i) state_d = acc_bad ? ST_RESP : ST_REQ;
            ST_REQ:  if (bus.mem_gnt_i)   state_d = ST_WAIT;
            ST_WAIT: if (bus.mem_rvalid_i || tmo_hit) state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= LSU_ERR_OK;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (bus.req_valid_i) begin
                    op_q    <= bus.lsu_opcode_i;
                    addr_q  <= bus.addr_i;
                    wdata_q <= bus.wdata_i;
                    if (acc_bad) begin
                        rdata_q <= '0;
                        err_q   <= LSU_ERR_MISALIGN;
                    end
                end
                ST_REQ:  tmo_q <= '0;
                ST_WAIT: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (bus.mem_rvalid_i) begin
                        rdata_q <= op_is_store(op_q) ? '0 : ld_data;
                        err_q   <= LSU_ERR_OK;
                    end else if (tmo_hit) begin
                        rdata_q <= '0;
                        err_q   <= LSU_ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32im_lsu_hs.sv
// Self-checking bench for rv32im_lsu_hs (DATA_W=32, TMO_W=8).
module tb_rv32im_lsu_hs;
    import rv32im_lsu_hs_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    rv32im_lsu_hs_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    rv32im_lsu_hs #(.DATA_W(32), .ADDR_W(32), .TMO_W(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // ---------------- reference model ----------------
    function automatic int m_bytes(input logic [3:0] op);
        case (op)
            LSU_OPCODE_LB, LSU_OPCODE_LBU, LSU_OPCODE_SB: return 1;
            LSU_OPCODE_LH, LSU_OPCODE_LHU, LSU_OPCODE_SH: return 2;
            LSU_OPCODE_LW, LSU_OPCODE_SW:                 return 4;
            default:                                      return 0;
        endcase
    endfunction

    function automatic bit m_store(input logic [3:0] op);
        return op == LSU_OPCODE_SB || op == LSU_OPCODE_SH || op == LSU_OPCODE_SW;
    endfunction

    function automatic bit m_bad(input logic [3:0] op, input logic [31:0] addr);
        int n = m_bytes(op);
        return (n == 0) || ((addr % n) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] word);
        int    n   = m_bytes(op);
        int    off = addr % 4;
        bit    sgn = (op == LSU_OPCODE_LB || op == LSU_OPCODE_LH || op == LSU_OPCODE_LW);
        longint v;
        longint range;
        if (m_store(op)) return 32'h0;
        range = longint'(1) << (8 * n);
        v = (longint'(word) >> (8 * off)) % range;
        if (sgn && v >= range / 2) v = v - range;
        return v[31:0];
    endfunction

    // ---------------- driver ----------------
    // Issues one request and plays the memory: grant after gnt_dly stalled
    // REQ cycles, completion after rv_dly idle WAIT cycles (rv_dly<0: never).
    // lat is counted in cycles after the accepting edge (-1 if no response).
    task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, wdata, mword,
                           input int gnt_dly, rv_dly,
                           output logic [31:0] r, output logic [1:0] e, output int lat,
                           output bit saw_req, output logic [68:0] req_f,
                           output bit stable, output bit quiet, output bit held);
        int req_n = 0;
        int wait_n = 0;
        bit granted = 0;
        r = '0; e = 2'b11; lat = -1; saw_req = 0; req_f = '0;
        stable = 1; quiet = 1; held = 0;
        @(negedge clk);
        bus.req_valid_i  = 1'b1;
        bus.lsu_opcode_i = op;
        bus.addr_i       = addr;
        bus.wdata_i      = wdata;
        @(negedge clk);
        bus.req_valid_i  = 1'b0;
        bus.lsu_opcode_i = 4'($urandom);
        bus.addr_i       = $urandom;
        bus.wdata_i      = $urandom;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = 1'b0;
            bus.mem_rdata_i  = $urandom;
            if (bus.rsp_valid_o) begin
                r = bus.rdata_o; e = bus.err_o; lat = cyc;
                break;
            end
            if (bus.mem_req_o) begin
                if (!saw_req)
                    req_f = {bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o, bus.mem_we_o};
                else if (req_f !== {bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o, bus.mem_we_o})
                    stable = 0;
                saw_req = 1;
                req_n++;
                if (req_n > gnt_dly) begin
                    bus.mem_gnt_i = 1'b1;
                    granted = 1;
                end
            end else begin
                if (bus.mem_we_o !== 1'b0 || bus.mem_be_o !== 4'h0) quiet = 0;
                if (granted) begin
                    wait_n++;
                    if (rv_dly >= 0 && wait_n == rv_dly + 1) begin
                        bus.mem_rvalid_i = 1'b1;
                        bus.mem_rdata_i  = mword;
                    end
                end
            end
            @(negedge clk);
        end
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
        if (lat > 0) begin
            @(negedge clk);
            held = (bus.rsp_valid_o === 1'b0) && (bus.req_ready_o === 1'b1) &&
                   (bus.rdata_o === r) && (bus.err_o === e);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.req_valid_i = 0; bus.lsu_opcode_i = 0; bus.addr_i = 0; bus.wdata_i = 0;
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.rsp_valid_o, bus.rdata_o, bus.err_o, bus.mem_req_o, bus.mem_we_o,
             bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== '0)
            $display("FAIL reset_outputs: got rsp=%b rdata=%h err=%0d req=%b we=%b be=%h addr=%h wdata=%h, want all zero",
                     bus.rsp_valid_o, bus.rdata_o, bus.err_o, bus.mem_req_o, bus.mem_we_o,
                     bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o);
        else n_pass++;
        n_checks++;
        if (bus.req_ready_o !== 1'b1)
            $display("FAIL reset_ready: got %b want 1", bus.req_ready_o);
        else n_pass++;
    endtask

    task automatic test_lb();
        logic [31:0] r; logic [1:0] e; int lat; bit sr, st, qu, hd; logic [68:0] f;
        run_txn(LSU_OPCODE_LB, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0, r, e, lat, sr, f, st, qu, hd);
        n_checks++;
        if (r !== 32'hFFFF_FF80 || e !== 2'd0)
            $display("FAIL lb_data: got rdata=%h err=%0d want rdata=ffffff80 err=0", r, e);
        else n_pass++;
        n_checks++;
        if (lat !== 3) $display("FAIL lb_latency: got %0d want 3", lat);
        else n_pass++;
        n_checks++;
        if (f[68:37] !== 32'h1000 || f[36:33] !== 4'b1000 || f[0] !== 1'b0)
            $display("FAIL lb_req: got addr=%h be=%b we=%b want 00001000 1000 0", f[68:37], f[36:33], f[0]);
        else n_pass++;
    endtask

    task automatic test_sh();
        logic [31:0] r; logic [1:0] e; int lat; bit sr, st, qu, hd; logic [68:0] f;
        run_txn(LSU_OPCODE_SH, 32'h2002, 32'h1234_ABCD, 32'hDEAD_BEEF, 0, 0, r, e, lat, sr, f, st, qu, hd);
        n_checks++;
        if (f !== {32'h2000, 4'b1100, 32'hABCD_0000, 1'b1})
            $display("FAIL sh_req: got addr=%h be=%b wdata=%h we=%b want 00002000 1100 abcd0000 1",
                     f[68:37], f[36:33], f[32:1], f[0]);
        else n_pass++;
        n_checks++;
        if (r !== 32'h0 || e !== 2'd0 || lat !== 3)
            $display("FAIL sh_rsp: got rdata=%h err=%0d lat=%0d want 0 0 3", r, e, lat);
        else n_pass++;
    endtask

    task automatic test_reject();
        logic [31:0] r; logic [1:0] e; int lat; bit sr, st, qu, hd; logic [68:0] f;
        logic [3:0] ops [3] = '{LSU_OPCODE_LW, LSU_OPCODE_LD, 4'hC};
        logic [31:0] adrs [3] = '{32'h1001, 32'h1000, 32'h1000};
        for (int i = 0; i < 3; i++) begin
            run_txn(ops[i], adrs[i], 32'h5555_AAAA, 32'h0, 0, 0, r, e, lat, sr, f, st, qu, hd);
            n_checks++;
            if (e !== 2'd1 || lat !== 1 || sr !== 1'b0 || hd !== 1'b1)
                $display("FAIL reject_%0d: got err=%0d lat=%0d mem_req_seen=%b held=%b want 1 1 0 1",
                         i, e, lat, sr, hd);
            else n_pass++;
        end
    endtask

    task automatic test_gnt_stall();
        logic [31:0] r; logic [1:0] e; int lat; bit sr, st, qu, hd; logic [68:0] f;
        run_txn(LSU_OPCODE_SW, 32'h4008, 32'hCAFE_F00D, 32'h0, 5, 0, r, e, lat, sr, f, st, qu, hd);
        n_checks++;
        if (st !== 1'b1 || f !== {32'h4008, 4'hF, 32'hCAFE_F00D, 1'b1})
            $display("FAIL stall_stable: got stable=%b addr=%h be=%h wdata=%h want 1 00004008 f cafef00d",
                     st, f[68:37], f[36:33], f[32:1]);
        else n_pass++;
        n_checks++;
        if (lat !== 8 || e !== 2'd0)
            $display("FAIL stall_done: got lat=%0d err=%0d want 8 0", lat, e);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] r, a, wd, mw, xr; logic [1:0] e; int lat, gd, rd, xl;
        bit sr, st, qu, hd, bad; logic [68:0] f; logic [3:0] op; int n;
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            a = $urandom; wd = $urandom; mw = $urandom;
            gd = $urandom_range(0, 3); rd = $urandom_range(0, 3);
            run_txn(op, a, wd, mw, gd, rd, r, e, lat, sr, f, st, qu, hd);
            bad = m_bad(op, a);
            n = m_bytes(op);
            xl = bad ? 1 : 3 + gd + rd;
            n_checks++;
            if (lat !== xl || hd !== 1'b1)
                $display("FAIL rand%0d_timing: op=%0d addr=%h got lat=%0d held=%b want %0d 1",
                         i, op, a, lat, hd, xl);
            else n_pass++;
            if (bad) begin
                n_checks++;
                if (e !== 2'd1 || sr !== 1'b0)
                    $display("FAIL rand%0d_reject: op=%0d addr=%h got err=%0d req=%b want 1 0", i, op, a, e, sr);
                else n_pass++;
            end else begin
                xr = m_load(op, a, mw);
                n_checks++;
                if (r !== xr || e !== 2'd0)
                    $display("FAIL rand%0d_rsp: op=%0d addr=%h mem=%h got rdata=%h err=%0d want %h 0",
                             i, op, a, mw, r, e, xr);
                else n_pass++;
                n_checks++;
                if (f !== {a & 32'hFFFF_FFFC, 4'(((1 << n) - 1) << (a % 4)),
                           32'(wd << (8 * (a % 4))), 1'(m_store(op))} || st !== 1'b1 || qu !== 1'b1)
                    $display("FAIL rand%0d_req: op=%0d addr=%h wd=%h got f=%h stable=%b quiet=%b",
                             i, op, a, wd, f, st, qu);
                else n_pass++;
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] r; logic [1:0] e; int lat; bit sr, st, qu, hd; logic [68:0] f;
        run_txn(LSU_OPCODE_LW, 32'h5000, 32'h0, 32'h0, 0, -1, r, e, lat, sr, f, st, qu, hd);
        n_checks++;
        if (e !== 2'd2 || r !== 32'h0 || lat !== 257)
            $display("FAIL timeout: got err=%0d rdata=%h lat=%0d want 2 0 257", e, r, lat);
        else n_pass++;
        run_txn(LSU_OPCODE_LHU, 32'h5006, 32'h0, 32'hF00D_1234, 1, 1, r, e, lat, sr, f, st, qu, hd);
        n_checks++;
        if (e !== 2'd0 || r !== 32'h0000_F00D || lat !== 5)
            $display("FAIL after_timeout: got err=%0d rdata=%h lat=%0d want 0 0000f00d 5", e, r, lat);
        else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        bit seen = 0;
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.lsu_opcode_i = LSU_OPCODE_LW;
        bus.addr_i = 32'h3000; bus.wdata_i = 32'h1111_2222;
        @(negedge clk);
        bus.req_valid_i = 1'b0; bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        bus.mem_gnt_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h8765_4321;
        @(negedge clk);
        bus.mem_rvalid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.rsp_valid_o !== 1'b0) seen = 1;
            @(negedge clk);
        end
        n_checks++;
        if (seen) $display("FAIL rst_wait_rsp: got rsp_valid=1 want 0");
        else n_pass++;
        n_checks++;
        if ({bus.rsp_valid_o, bus.rdata_o, bus.err_o, bus.mem_req_o, bus.mem_we_o,
             bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o, bus.req_ready_o} !== 105'h1)
            $display("FAIL rst_wait_outputs: got rdata=%h err=%0d req=%b addr=%h wdata=%h ready=%b want zeros, ready=1",
                     bus.rdata_o, bus.err_o, bus.mem_req_o, bus.mem_addr_o, bus.mem_wdata_o, bus.req_ready_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_reject();
        test_gnt_stall();
        test_random();
        test_timeout();
        test_reset_in_wait();
        test_lb();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
